// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Single-port word memory with an LC-3 style request/ready handshake.
//   A request is latched in IDLE, held for WAIT_CYCLES wait states, answered
//   with a one-cycle mem_ready pulse, and then the FSM parks in DONE until the
//   CPU drops mem_req. This way one held request yields exactly one response.
//
//   Optional feature (compile-time macro MEM_RESPONDER_MMIO_EN):
//     address 16'hFFFF becomes memory-mapped I/O. Reads return `switches`
//     and writes load `hex_out`. Without the macro, 16'hFFFF is an ordinary
//     out-of-range address, hex_out is tied to zero and `switches` is unused.
//
// Parameters
//   ADDR_W       word-address width of the storage (depth 2**ADDR_W x 16)
//   WAIT_CYCLES  wait states before each response (0..15)
//
// Ports
//   Clk        clock, all state changes on the rising edge
//   Reset      synchronous active-low reset
//   mem_req    access request, held high until mem_ready is seen
//   mem_we     1 = write, 0 = read
//   mem_addr   word address
//   mem_wdata  write data
//   switches   board switch value (MMIO read source)
//   mem_rdata  read data, valid while mem_ready is high, holds otherwise
//   mem_ready  one-cycle response pulse
//   hex_out    MMIO display register
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  input  logic [15:0] switches,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  output logic [15:0] hex_out
);

  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [15:0] MMIO_ADDR = 16'hFFFF;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
`ifdef MEM_RESPONDER_MMIO_EN
  localparam bit          MMIO_EN   = 1'b1;
`else
  localparam bit          MMIO_EN   = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DONE} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        we_q;
  logic [15:0] rd_addr;
  logic [15:0] rd_value;
  logic        commit_en;
  logic [15:0] mem [DEPTH];

  // True when the address falls inside the storage array.
  function automatic logic in_range(input logic [15:0] a);
    return (32'(a) >> ADDR_W) == 32'd0;
  endfunction

  // MMIO takes priority over storage decode (matters only when ADDR_W=16).
  function automatic logic is_mmio(input logic [15:0] a);
    return MMIO_EN && (a == MMIO_ADDR);
  endfunction

  // With zero wait states the response is produced on the acceptance edge,
  // before addr_q has been loaded, so the read must look at the live address.
  assign rd_addr = (state == IDLE) ? mem_addr : addr_q;

  always_comb begin
    rd_value = 16'h0000;
    if (is_mmio(rd_addr)) begin
`ifdef MEM_RESPONDER_MMIO_EN
      rd_value = switches;
`endif
    end else if (in_range(rd_addr)) begin
      rd_value = mem[rd_addr[ADDR_W-1:0]];
    end
  end

  // Request capture: only the values seen at acceptance matter afterwards.
  always_ff @(posedge Clk) begin
    if (state == IDLE && mem_req) begin
      addr_q  <= mem_addr;
      we_q    <= mem_we;
      wdata_q <= mem_wdata;
    end
  end

  // Writes commit as RESP is left; a reset in RESP suppresses the commit.
  assign commit_en = Reset && (state == RESP) && we_q &&
                     !is_mmio(addr_q) && in_range(addr_q);

  // Storage has no reset so its contents survive a Reset pulse.
  always_ff @(posedge Clk) begin
    if (commit_en) begin
      mem[addr_q[ADDR_W-1:0]] <= wdata_q;
    end
  end

  // Handshake FSM with registered mem_ready / mem_rdata.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      mem_ready <= 1'b0;
      mem_rdata <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            wait_cnt <= WAIT_INIT;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              mem_ready <= 1'b1;
              if (!mem_we) mem_rdata <= rd_value;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state     <= RESP;
            mem_ready <= 1'b1;
            if (!we_q) mem_rdata <= rd_value;
          end
        end
        RESP: begin
          mem_ready <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          // Parked until the CPU releases the request, so a held request
          // cannot be answered twice.
          if (!mem_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_RESPONDER_MMIO_EN
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      hex_out <= 16'h0000;
    end else if (state == RESP && we_q && is_mmio(addr_q)) begin
      hex_out <= wdata_q;
    end
  end
`else
  logic unused_switches;
  assign unused_switches = ^switches;
  assign hex_out         = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Two instances are exercised: index 0 with WAIT_CYCLES=2, index 1 with
//   WAIT_CYCLES=0. A behavioural model holds the expected storage contents
//   and display register, and the expected handshake latency is WAIT_CYCLES+1
//   cycles counted from the acceptance edge.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int ADDR_W = 10;
`ifdef MEM_RESPONDER_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        req   [2];
  logic        we_s  [2];
  logic [15:0] addr  [2];
  logic [15:0] wdata [2];
  logic [15:0] sw    [2];
  logic [15:0] rdata [2];
  logic        ready [2];
  logic [15:0] hex   [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mdl [int];
  logic [15:0] exp_hex [2];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) u_dut_w2 (
    .Clk(clk), .Reset(rst_n[0]), .mem_req(req[0]), .mem_we(we_s[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .switches(sw[0]),
    .mem_rdata(rdata[0]), .mem_ready(ready[0]), .hex_out(hex[0])
  );

  mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_dut_w0 (
    .Clk(clk), .Reset(rst_n[1]), .mem_req(req[1]), .mem_we(we_s[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .switches(sw[1]),
    .mem_rdata(rdata[1]), .mem_ready(ready[1]), .hex_out(hex[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete handshake on instance d; inputs are scrambled right after
  // acceptance and mem_req is held for `hold` extra cycles after the pulse.
  task automatic access(input int d, input logic we, input logic [15:0] a,
                        input logic [15:0] wd, input int hold,
                        output logic [15:0] rd);
    int n;
    int extra;
    int w;
    w = (d == 0) ? 2 : 0;
    req[d] = 1'b1; we_s[d] = we; addr[d] = a; wdata[d] = wd;
    @(posedge clk); #1;
    we_s[d] = 1'($urandom); addr[d] = 16'($urandom); wdata[d] = 16'($urandom);
    n = 1;
    while (!ready[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("latency_d%0d", d), n, w + 1);
    rd = rdata[d];
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (ready[d]) extra++;
    end
    chk($sformatf("single_pulse_d%0d", d), extra, 0);
    req[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  // Model-checked transaction.
  task automatic run(input int d, input logic we, input logic [15:0] a,
                     input logic [15:0] wd, input int hold);
    logic [15:0] rd;
    logic [15:0] exp;
    logic        known;
    int          k;
    known = 1'b1;
    exp   = 16'h0000;
    k     = d * 65536 + int'(a);
    if (MMIO && a == 16'hFFFF) begin
      if (we) exp_hex[d] = wd;
      else    exp = sw[d];
    end else if (int'(a) < (1 << ADDR_W)) begin
      if (we) mdl[k] = wd;
      else if (mdl.exists(k)) exp = mdl[k];
      else known = 1'b0;
    end
    access(d, we, a, wd, hold, rd);
    if (!we && known) chk($sformatf("rdata_d%0d_a%04h", d, a), rd, exp);
    chk($sformatf("hex_d%0d", d), hex[d], exp_hex[d]);
  endtask

  initial begin
    logic [15:0] rd;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; we_s[d] = 1'b0;
      addr[d] = 16'h0; wdata[d] = 16'h0; sw[d] = 16'h0; exp_hex[d] = 16'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready_d%0d", d), ready[d], 0);
      chk($sformatf("rst_rdata_d%0d", d), rdata[d], 0);
      chk($sformatf("rst_hex_d%0d", d), hex[d], 0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // Basic write then read-back, long hold on the read.
    run(0, 1'b1, 16'h0005, 16'h1234, 1);
    run(0, 1'b0, 16'h0005, 16'h0000, 10);
    run(1, 1'b1, 16'h0005, 16'h4321, 1);
    run(1, 1'b0, 16'h0005, 16'h0000, 10);

    // Out-of-range write leaves aliased word 0 alone and reads back zero.
    run(0, 1'b1, 16'h0000, 16'h0F0F, 1);
    run(0, 1'b1, 16'h0400, 16'hBEEF, 2);
    run(0, 1'b0, 16'h0400, 16'h0000, 1);
    run(0, 1'b0, 16'h0000, 16'h0000, 1);

    // 16'hFFFF: MMIO when enabled, out-of-range otherwise.
    run(0, 1'b1, 16'h03FF, 16'h7777, 1);
    sw[0] = 16'h00AB;
    run(0, 1'b0, 16'hFFFF, 16'h0000, 1);
    run(0, 1'b1, 16'hFFFF, 16'h0C0F, 1);
    run(0, 1'b0, 16'h03FF, 16'h0000, 1);
    sw[1] = 16'h5A5A;
    run(1, 1'b0, 16'hFFFF, 16'h0000, 1);
    run(1, 1'b1, 16'hFFFF, 16'h3C3C, 1);

    // Reset during BUSY aborts the write; storage keeps the prior value.
    run(0, 1'b1, 16'h0010, 16'hAAAA, 1);
    req[0] = 1'b1; we_s[0] = 1'b1; addr[0] = 16'h0010; wdata[0] = 16'h5555;
    @(posedge clk); #1;
    rst_n[0] = 1'b0;
    @(posedge clk); #1;
    req[0] = 1'b0;
    chk("abort_ready", ready[0], 0);
    chk("abort_rdata", rdata[0], 0);
    exp_hex[0] = 16'h0000;
    chk("abort_hex", hex[0], 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_pulse", ready[0], 0);
    end
    rst_n[0] = 1'b1;
    run(0, 1'b0, 16'h0010, 16'h0000, 1);

    // Randomized traffic on both instances.
    for (int it = 0; it < 120; it++) begin
      for (int d = 0; d < 2; d++) begin
        int          cls;
        logic [15:0] a;
        cls = $urandom_range(0, 9);
        if (cls <= 6)      a = 16'($urandom_range(0, 31));
        else if (cls == 7) a = 16'($urandom_range(1024, 16'hFFFE));
        else if (cls == 8) a = 16'hFFFF;
        else               a = 16'($urandom_range(0, 1023));
        sw[d] = 16'($urandom);
        run(d, 1'($urandom), a, 16'($urandom), $urandom_range(1, 3));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of on-chip storage (depth 2**ADDR_W x 16).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted before each response (0..15).
REQ-003 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 Reset  input  1  synchronous, active-low reset, sampled on posedge Clk.
REQ-005 mem_req  input  1  CPU access request, held high until mem_ready seen.
REQ-006 mem_we  input  1  1 = write, 0 = read; valid while mem_req high.
REQ-007 mem_addr  input  16  word address (CPU MAR value).
REQ-008 mem_wdata  input  16  write data (CPU MDR value).
REQ-009 switches  input  16  board switch value, readable via MMIO.
REQ-010 mem_rdata  output  16  read data, valid in the cycle mem_ready is high.
REQ-011 mem_ready  output  1  one-cycle response pulse (LC-3 R signal).
REQ-012 hex_out  output  16  MMIO display register driving hex digits.

Function
REQ-013 FSM states IDLE, BUSY, RESP, DONE; exactly one active at a time.
REQ-014 IDLE: mem_req=1 at a posedge latches mem_addr, mem_we and mem_wdata, loads wait counter with WAIT_CYCLES, and moves to BUSY (or to RESP when WAIT_CYCLES=0).
REQ-015 BUSY: counter decrements each cycle; counter reaching 1 moves to RESP on the next edge.
REQ-016 Latency: request sampled at edge T yields mem_ready high in cycle T+WAIT_CYCLES+1.
REQ-017 RESP: mem_ready=1 for exactly one cycle; reads drive mem_rdata from the latched address; writes commit at the RESP-exit edge; next state DONE.
REQ-018 DONE: mem_ready=0; stays until mem_req=0, then IDLE; a request held high never produces a second response.
REQ-019 Latched address/data only are used; input changes after acceptance have no effect on the access in flight.
REQ-020 Address decode: mem_addr < 2**ADDR_W selects storage word mem_addr[ADDR_W-1:0].
REQ-021 Out-of-range non-MMIO address: read returns 16'h0000; write discarded; handshake timing unchanged.
REQ-022 mem_rdata holds its last value outside RESP; it is not required to be zero.
REQ-023 Storage is not initialised; read-before-write contents are undefined.

Reset
REQ-024 Reset=0 at posedge forces state IDLE, counter 0, mem_ready 0, mem_rdata 16'h0000, hex_out 16'h0000.
REQ-025 Reset mid-access (BUSY/RESP/DONE) aborts it: no mem_ready pulse, pending write not committed.
REQ-026 Storage contents are unaffected by reset.
REQ-027 First request is accepted at the first edge after Reset returns high.

Configuration
REQ-028 Macro MEM_RESPONDER_MMIO_EN compiles in memory-mapped I/O.
REQ-029 Defined: read of 16'hFFFF returns switches sampled in RESP; write to 16'hFFFF loads hex_out at the RESP-exit edge; neither touches storage.
REQ-030 Undefined: 16'hFFFF follows the out-of-range rule (REQ-021); hex_out is constant 16'h0000; switches is unused.

Verification
REQ-031 WAIT_CYCLES=2: write 16'h1234 to 16'h0005, then read 16'h0005 -> mem_ready 3 cycles after each acceptance, mem_rdata=16'h1234.
REQ-032 mem_req held high for 10 cycles after one read -> exactly one mem_ready pulse; lowering mem_req returns the FSM to IDLE.
REQ-033 MMIO_EN defined: switches=16'h00AB, read 16'hFFFF -> mem_rdata=16'h00AB; write 16'h0C0F to 16'hFFFF -> hex_out=16'h0C0F, storage word 16'h03FF unchanged.
REQ-034 Write 16'hBEEF to 16'h0400 (ADDR_W=10) -> mem_ready timed normally; read 16'h0400 -> 16'h0000; word 16'h0000 unchanged.
REQ-035 Write 16'h5555 to 16'h0010 with Reset=0 during BUSY -> no mem_ready; subsequent read of 16'h0010 returns prior value 16'hAAAA.
REQ-036 WAIT_CYCLES=0: read accepted at edge T -> mem_ready high in cycle T+1.
